control_unit: RTL and testbench



---
 rtl/control_pkg.sv | 31 +++
 rtl/control_if.sv | 23 ++
 rtl/control_decoder.sv | 39 +++
 rtl/control_unit.sv | 40 ++++
 tb/tb_control_unit.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared opcode map and strobe encoding for the control unit.
package control_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_MOV = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_LD  = 4'b1011;
    localparam logic [3:0] OP_ST  = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;
    localparam logic [3:0] OP_BEQ = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // All strobes active low; field order fixes the packed bit order.
    typedef struct packed {
        logic n_reg_w;
        logic n_mem_rw;
        logic n_mem_cs;
        logic n_mem_oe;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = 4'b1111;

endpackage

// File: rtl/control_if.sv
// Opcode in, registered strobes and halt flag out.
interface control_if;
    import control_pkg::*;

    logic [3:0] opCode;
    logic       n_reg_w;
    logic       n_mem_rw;
    logic       n_mem_cs;
    logic       n_mem_oe;
    logic       halted;

    // Instruction-side view: drives the opcode, watches the strobes.
    modport master (
        output opCode,
        input  n_reg_w, n_mem_rw, n_mem_cs, n_mem_oe, halted
    );

    // Control unit view.
    modport slave (
        input  opCode,
        output n_reg_w, n_mem_rw, n_mem_cs, n_mem_oe, halted
    );
endinterface

// File: rtl/control_decoder.sv
// Pure combinational opcode decode into next-cycle strobes.
module control_decoder
    import control_pkg::*;
(
    input  logic [3:0] opCode,
    output strobes_t   strobes,
    output logic       is_hlt
);

    // Opcode map; anything without a strobe falls back to idle.
    always_comb begin
        strobes = STROBES_IDLE;
        is_hlt  = 1'b0;
        case (opCode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_NOT, OP_SHL, OP_SHR, OP_MOV, OP_LDI: begin
                strobes.n_reg_w = 1'b0;
            end
            OP_LD: begin
                strobes.n_reg_w  = 1'b0;
                strobes.n_mem_cs = 1'b0;
                strobes.n_mem_rw = 1'b1;
                strobes.n_mem_oe = 1'b0;
            end
            OP_ST: begin
                strobes.n_mem_cs = 1'b0;
                strobes.n_mem_rw = 1'b0;
                strobes.n_mem_oe = 1'b1;
            end
            OP_HLT: begin
                is_hlt = 1'b1;
            end
            default: begin
                strobes = STROBES_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Registers decoded strobes and holds the sticky halt flag.
module control_unit
    import control_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    control_if.slave  bus
);

    strobes_t dec_strobes;
    logic     dec_is_hlt;
    strobes_t strobes_q;
    logic     halted_q;

    control_decoder u_dec (
        .opCode  (bus.opCode),
        .strobes (dec_strobes),
        .is_hlt  (dec_is_hlt)
    );

    // Output register: reset beats halt, halt (current or just decoded) forces idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobes_q <= STROBES_IDLE;
            halted_q  <= 1'b0;
        end else if (halted_q || dec_is_hlt) begin
            strobes_q <= STROBES_IDLE;
            halted_q  <= 1'b1;
        end else begin
            strobes_q <= dec_strobes;
        end
    end

    assign bus.n_reg_w  = strobes_q.n_reg_w;
    assign bus.n_mem_rw = strobes_q.n_mem_rw;
    assign bus.n_mem_cs = strobes_q.n_mem_cs;
    assign bus.n_mem_oe = strobes_q.n_mem_oe;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed plus random checks of control_unit against a behavioural model.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: strobes as {n_reg_w, n_mem_rw, n_mem_cs, n_mem_oe}.
    logic [3:0] m_strobes = 4'b1111;
    logic       m_halted  = 1'b0;

    logic [3:0] gray [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    control_if cif ();

    control_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (cif.slave)
    );

    always #5 clk = ~clk;

    // Opcode rules: ALU/MOV/LDI/LD write the register file, LD reads memory, ST writes it.
    function automatic logic [3:0] ref_strobes(input logic [3:0] op);
        bit reg_wr = (op >= 4'd1) && (op <= 4'd11);
        bit mem_rd = (op == 4'd11);
        bit mem_wr = (op == 4'd12);
        return {~reg_wr, ~mem_wr, ~(mem_rd | mem_wr), ~mem_rd};
    endfunction

    task automatic model_edge(input logic [3:0] op, input logic r);
        if (r) begin
            m_halted  = 1'b0;
            m_strobes = 4'b1111;
        end else if (m_halted || op == 4'd15) begin
            m_halted  = 1'b1;
            m_strobes = 4'b1111;
        end else begin
            m_strobes = ref_strobes(op);
        end
    endtask

    task automatic check(input string tag);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {cif.halted, cif.n_reg_w, cif.n_mem_rw, cif.n_mem_cs, cif.n_mem_oe};
        exp = {m_halted, m_strobes};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Strobe invariants evaluated on the DUT outputs alone.
    task automatic check_inv(input string tag);
        logic ok;
        ok = 1'b1;
        if (cif.n_mem_oe === 1'b0 && !(cif.n_mem_rw === 1'b1 && cif.n_mem_cs === 1'b0)) ok = 1'b0;
        if (cif.n_mem_rw === 1'b0 && !(cif.n_mem_cs === 1'b0 && cif.n_mem_oe === 1'b1)) ok = 1'b0;
        if (cif.n_mem_cs === 1'b1 && !(cif.n_mem_rw === 1'b1 && cif.n_mem_oe === 1'b1)) ok = 1'b0;
        vectors++;
        assert (ok === 1'b1) else begin
            miscompares++;
            $error("FAIL %s observed=%b%b%b expected=legal strobe combination",
                   tag, cif.n_mem_rw, cif.n_mem_cs, cif.n_mem_oe);
        end
    endtask

    // Drive one cycle, advance the model on the edge, then sample 1 time unit later.
    task automatic step(input logic [3:0] op, input logic r, input string tag);
        cif.opCode = op;
        rst = r;
        @(posedge clk);
        model_edge(op, r);
        #1;
        check(tag);
        check_inv({tag, "_inv"});
    endtask

    initial begin
        cif.opCode = 4'b0000;

        // Reset with LD presented.
        step(4'b1011, 1'b1, "reset0");
        step(4'b1011, 1'b1, "reset1");

        // Gray-code sweep; HLT in the middle locks the rest.
        for (int i = 0; i < 16; i++) step(gray[i], 1'b0, $sformatf("gray_%b", gray[i]));

        // LD then ST back to back.
        step(4'b0000, 1'b1, "ldst_rst");
        step(4'b1011, 1'b0, "ldst_ld");
        step(4'b1100, 1'b0, "ldst_st");

        // Reset during LD and ST forces idle.
        step(4'b1011, 1'b0, "ld_pre");
        step(4'b1011, 1'b1, "ld_rst");
        step(4'b1100, 1'b0, "st_pre");
        step(4'b1100, 1'b1, "st_rst");

        // Held opcode keeps strobes steady.
        step(4'b1011, 1'b0, "hold0");
        step(4'b1011, 1'b0, "hold1");
        step(4'b1011, 1'b0, "hold2");

        // Halt recovery.
        step(4'b1111, 1'b0, "hlt");
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, $sformatf("hlt_add%0d", i));
        step(4'b0001, 1'b1, "hlt_rst");
        step(4'b0001, 1'b0, "hlt_after");

        // Mid-cycle toggles: only the value at the edge counts, outputs stay put meanwhile.
        cif.opCode = 4'b1100; #2;
        cif.opCode = 4'b0000; #2;
        check("mid_stable0");
        cif.opCode = 4'b1100; #2;
        step(4'b0000, 1'b0, "mid_edge_nop");
        cif.opCode = 4'b0000; #2;
        cif.opCode = 4'b1100; #2;
        check("mid_stable1");
        cif.opCode = 4'b0000; #2;
        step(4'b1100, 1'b0, "mid_edge_st");

        // Random run with occasional resets so halt does not dominate.
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] op;
            logic       r;
            op = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 7) == 0);
            step(op, r, $sformatf("rand%0d_op%b_r%b", i, op, r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
